// File: rtl/std_mem_arb2.sv
// std_mem_arb2 -- two-requester round-robin arbiter in front of a single-port
// 1-D memory. One access is in flight at a time. A read takes one memory
// cycle. A write strobes the memory for one cycle and then waits for
// mem_done. Each access finishes with a one-cycle done pulse to its requester.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   rN_go               request from requester N (N=0,1), held until rN_done
//   rN_addr0            requester N address
//   rN_write_data       requester N write data
//   rN_write_en         1=write, 0=read
//   rN_read_data        last read result for requester N (registered)
//   rN_done             one-cycle completion pulse
//   mem_addr0           memory address
//   mem_write_data      memory write data
//   mem_write_en        memory write enable
//   mem_read_data       combinational memory read data
//   mem_done            write acknowledge, high the cycle after a write edge

// Per-requester read-result holding register.
module std_mem_arb2_rdreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

module std_mem_arb2 #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_go,
  input  logic [IDX_SIZE-1:0] r0_addr0,
  input  logic [WIDTH-1:0]    r0_write_data,
  input  logic                r0_write_en,
  output logic [WIDTH-1:0]    r0_read_data,
  output logic                r0_done,
  input  logic                r1_go,
  input  logic [IDX_SIZE-1:0] r1_addr0,
  input  logic [WIDTH-1:0]    r1_write_data,
  input  logic                r1_write_en,
  output logic [WIDTH-1:0]    r1_read_data,
  output logic                r1_done,
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic [WIDTH-1:0]    mem_write_data,
  output logic                mem_write_en,
  input  logic [WIDTH-1:0]    mem_read_data,
  input  logic                mem_done
);
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [IDX_SIZE-1:0] addr;
    logic [WIDTH-1:0]    data;
    logic                we;
  } req_t;

  typedef enum logic [2:0] {IDLE, READ, WRITE, WAIT, DONE} state_t;

  state_t                          state;
  logic                            grant;
  logic                            last_grant;
  req_t                            lat;
  logic [NUM_REQ-1:0]              go;
  req_t [NUM_REQ-1:0]              req;
  logic                            pick;
  logic [NUM_REQ-1:0]              done;
  logic [NUM_REQ-1:0][WIDTH-1:0]   rd_data;

  assign go     = {r1_go, r0_go};
  assign req[0] = {r0_addr0, r0_write_data, r0_write_en};
  assign req[1] = {r1_addr0, r1_write_data, r1_write_en};

  // On a tie the requester that was not served last wins; otherwise the
  // single active requester (go[1] selects index 1).
  assign pick = (&go) ? ~last_grant : go[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      lat        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|go) begin
            grant <= pick;
            lat   <= req[pick];
            state <= req[pick].we ? WRITE : READ;
          end
        end
        READ:    state <= DONE;
        WRITE:   state <= WAIT;
        WAIT:    if (mem_done) state <= DONE;
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side is decoded from state and latched request only, so a go
  // toggling mid-access never reaches the memory pins.
  logic addr_phase;
  logic wr_phase;
  assign addr_phase     = (state == READ) || (state == WRITE) || (state == WAIT);
  assign wr_phase       = lat.we && addr_phase;
  assign mem_addr0      = addr_phase ? lat.addr : '0;
  assign mem_write_data = wr_phase   ? lat.data : '0;
  assign mem_write_en   = (state == WRITE);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign done[i] = (state == DONE) && (grant == 1'(i));

    std_mem_arb2_rdreg #(.WIDTH(WIDTH)) u_rdreg (
      .clk   (clk),
      .reset (reset),
      .load  ((state == READ) && (grant == 1'(i))),
      .d     (mem_read_data),
      .q     (rd_data[i])
    );
  end

  assign r0_done      = done[0];
  assign r1_done      = done[1];
  assign r0_read_data = rd_data[0];
  assign r1_read_data = rd_data[1];

  // Out-of-range address check, once per granted access (first access cycle).
  logic [31:0] addr_ext;
  assign addr_ext = 32'(lat.addr);
  always_ff @(posedge clk) begin
    if (!reset && ((state == READ) || (state == WRITE)) && (addr_ext >= 32'(SIZE)))
      $error("std_mem_arb2: address %0d out of range (SIZE=%0d)", addr_ext, SIZE);
  end

endmodule

// File: tb/tb_std_mem_arb2.sv
// Bench for std_mem_arb2: behavioural memory, a timestamp-based reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_std_mem_arb2;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  go = '0;
  logic [1:0]  we = '0;
  logic [3:0]  addr [2];
  logic [31:0] wd   [2];

  logic [31:0] r0_read_data, r1_read_data;
  logic        r0_done, r1_done;
  logic [3:0]  mem_addr0;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic [31:0] mem_read_data;
  logic        mem_done;

  always #5 clk = ~clk;

  std_mem_arb2 #(.WIDTH(32), .SIZE(16), .IDX_SIZE(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .r0_go          (go[0]),
    .r0_addr0       (addr[0]),
    .r0_write_data  (wd[0]),
    .r0_write_en    (we[0]),
    .r0_read_data   (r0_read_data),
    .r0_done        (r0_done),
    .r1_go          (go[1]),
    .r1_addr0       (addr[1]),
    .r1_write_data  (wd[1]),
    .r1_write_en    (we[1]),
    .r1_read_data   (r1_read_data),
    .r1_done        (r1_done),
    .mem_addr0      (mem_addr0),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data),
    .mem_done       (mem_done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem [16];
  int          wdelay = 1;
  int          ack_cnt = 0;
  assign mem_read_data = mem[mem_addr0];
  assign mem_done      = (ack_cnt == 1);
  always @(posedge clk) begin
    if (mem_write_en === 1'b1) begin
      mem[mem_addr0] <= mem_write_data;
      ack_cnt        <= wdelay;
    end else if (ack_cnt > 0) begin
      ack_cnt <= ack_cnt - 1;
    end
  end

  // ---------------- reference model ----------------
  // Works in absolute cycle numbers: a grant in cycle t means the memory
  // access happens in t+1, a read completes in t+2, a write completes the
  // cycle after mem_done is seen.
  int          cyc = 0;
  bit          model_ok = 0;
  bit          m_busy = 0;
  int          m_g = 0;
  int          m_last = 1;
  bit          m_we = 0;
  logic [3:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          acc_at = 0;
  int          done_at = -1;
  logic [31:0] e_rd [2];

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_last = 1; e_rd[0] = '0; e_rd[1] = '0; model_ok = 1;
    end else if (model_ok) begin
      if (m_busy && cyc == done_at) begin
        m_last = m_g; m_busy = 0;
      end else if (!m_busy && (go[0] || go[1])) begin
        m_g     = (go[0] && go[1]) ? 1 - m_last : (go[0] ? 0 : 1);
        m_we    = we[m_g];
        m_addr  = addr[m_g];
        m_data  = wd[m_g];
        m_busy  = 1;
        acc_at  = cyc + 1;
        done_at = m_we ? -1 : cyc + 2;
      end else if (m_busy) begin
        if (!m_we && cyc == acc_at) e_rd[m_g] = mem[m_addr];
        if (m_we && done_at < 0 && cyc > acc_at && mem_done) done_at = cyc + 1;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit act;
    if (model_ok) begin
      act = m_busy && cyc >= acc_at && cyc != done_at;
      chk("mem_write_en", mem_write_en, 64'(m_busy && m_we && cyc == acc_at));
      chk("mem_addr0", mem_addr0, act ? 64'(m_addr) : 64'd0);
      chk("mem_write_data", mem_write_data, (act && m_we) ? 64'(m_data) : 64'd0);
      chk("r0_done", r0_done, 64'(m_busy && cyc == done_at && m_g == 0));
      chk("r1_done", r1_done, 64'(m_busy && cyc == done_at && m_g == 1));
      chk("r0_read_data", r0_read_data, 64'(e_rd[0]));
      chk("r1_read_data", r1_read_data, 64'(e_rd[1]));
    end
  end

  // ---------------- driver ----------------
  int          rem [2] = '{0, 0};
  int          order [$];
  int          done_cyc [2];
  int          we_cnt;
  logic [3:0]  we_addr;
  logic [31:0] we_data;

  task automatic do_reset();
    reset = 1'b1;
    go    = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Steps cycles from posedge+1, recording done order and write strobes;
  // each requester drops go after its done unless it has more requests.
  task automatic run(input int budget);
    bit seen [2];
    seen = '{0, 0};
    order.delete();
    done_cyc = '{-1, -1};
    we_cnt = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (mem_write_en) begin
        we_cnt++; we_addr = mem_addr0; we_data = mem_write_data;
      end
      if (r0_done) begin order.push_back(0); done_cyc[0] = c; seen[0] = 1; end
      if (r1_done) begin order.push_back(1); done_cyc[1] = c; seen[1] = 1; end
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (seen[n]) begin
          seen[n] = 0;
          if (rem[n] > 0) rem[n]--;
          else go[n] = 1'b0;
        end
      end
      if (!go[0] && !go[1]) return;
    end
    tests++; fails++;
    $display("FAIL run_timeout: got go=%b still pending want all done within %0d cycles", go, budget);
    go = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ord [5];
    int dn, md;
    exp_ord = '{0, 1, 0, 1, 0};
    addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);
    mem[3] = 32'hAB;
    mem[7] = 32'h777;

    // Reset values.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_r0_done", r0_done, 0);
    chk("rst_r1_done", r1_done, 0);
    chk("rst_mem_we", mem_write_en, 0);
    chk("rst_mem_addr", mem_addr0, 0);
    chk("rst_r0_rd", r0_read_data, 0);
    chk("rst_r1_rd", r1_read_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // r0 read of addr 3.
    addr[0] = 4'd3; we[0] = 1'b0; go[0] = 1'b1;
    run(20);
    chk("rd_latency", done_cyc[0], 2);
    chk("rd_data_r0", r0_read_data, 32'hAB);
    chk("rd_no_we", we_cnt, 0);

    // r1 write of 0x1234 to addr 5, immediate ack.
    wdelay = 1;
    addr[1] = 4'd5; wd[1] = 32'h1234; we[1] = 1'b1; go[1] = 1'b1;
    run(20);
    chk("wr_latency", done_cyc[1], 3);
    chk("wr_we_cycles", we_cnt, 1);
    chk("wr_addr", we_addr, 5);
    chk("wr_data", we_data, 32'h1234);
    chk("wr_mem5", mem[5], 32'h1234);
    chk("wr_r0_rd_kept", r0_read_data, 32'hAB);

    // r0 write with a slow ack: done two cycles later than the fast case.
    wdelay = 3;
    addr[0] = 4'd6; wd[0] = 32'hBEEF; we[0] = 1'b1; go[0] = 1'b1;
    run(20);
    chk("wr_slow_latency", done_cyc[0], 5);
    chk("wr_slow_mem6", mem[6], 32'hBEEF);
    wdelay = 1;

    // Tie after reset: r0 first; r0 re-requests while r1 waits -> r1 next.
    do_reset();
    addr[0] = 4'd1; we[0] = 1'b0; addr[1] = 4'd2; we[1] = 1'b0;
    rem[0] = 1; rem[1] = 0; go = 2'b11;
    run(40);
    chk("tie_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("tie_first", order[0], 0);
      chk("tie_second", order[1], 1);
      chk("tie_third", order[2], 0);
    end
    chk("tie_r1_rd", r1_read_data, 32'h102);
    chk("tie_r0_rd", r0_read_data, 32'h101);

    // Both hold go across back-to-back requests: strict alternation.
    do_reset();
    rem[0] = 2; rem[1] = 1; go = 2'b11;
    run(60);
    chk("rr_count", order.size(), 5);
    if (order.size() == 5)
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), order[k], exp_ord[k]);

    // Address change after grant has no effect.
    addr[0] = 4'd2; we[0] = 1'b0; go[0] = 1'b1;
    @(posedge clk); #1;
    addr[0] = 4'd7;
    run(20);
    chk("late_addr_latency", done_cyc[0], 1);
    chk("late_addr_rd", r0_read_data, 32'h102);

    // Reset while waiting for a write ack; the late ack must be ignored.
    wdelay = 4;
    addr[0] = 4'd9; wd[0] = 32'h55; we[0] = 1'b1; go[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    go[0] = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dn = 0; md = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (r0_done || r1_done) dn++;
      if (mem_done) md++;
    end
    chk("abort_memdone_seen", md, 1);
    chk("abort_no_done", dn, 0);
    chk("abort_we", mem_write_en, 0);
    chk("abort_addr", mem_addr0, 0);
    chk("abort_r0_rd", r0_read_data, 0);
    chk("abort_r1_rd", r1_read_data, 0);
    @(posedge clk); #1;
    wdelay = 1;

    // Back in IDLE: a fresh read has the normal latency.
    addr[0] = 4'd3; we[0] = 1'b0; go[0] = 1'b1;
    run(20);
    chk("post_abort_latency", done_cyc[0], 2);
    chk("post_abort_rd", r0_read_data, 32'hAB);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
